ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 keyboard receiver: samples scl/sda on a divided tick, filters glitches and frames 11-bit packets.
//  Checks start, odd parity and stop; aborts stalled frames by timeout; folds E0/F0 prefixes into flags.
//  Buffers decoded bytes in a show-ahead FIFO with valid/rd_en handshake.
//  Sits between the keyboard pins and downstream key logic (LED display, command decoder).
// PARAMETERS
//  CLK_DIV       250   clk cycles per sample tick (>=2); tick = 1-cycle pulse
//  FILTER_LEN    4     consecutive equal ticks needed before filtered scl/sda change (>=1)
//  TIMEOUT       4000  ticks without an scl falling edge in RECV before the frame is aborted
//  FIFO_DEPTH    8     FIFO entries; power of 2, >=2
//  DECODE_PREFIX 1     1: E0/F0 become flags, not FIFO entries; 0: every byte pushed, flags always 0
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active-high
//  scl         in   1   PS/2 clock from keyboard (asynchronous)
//  sda         in   1   PS/2 data from keyboard (asynchronous)
//  rd_en       in   1   pop head entry; ignored when valid=0
//  valid       out  1   FIFO not empty; data_out/ext/brk hold the head entry
//  data_out    out  8   head scan code
//  ext         out  1   head entry was preceded by E0
//  brk         out  1   head entry was preceded by F0 (key release)
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently stored
//  parity_err  out  1   1-cycle pulse: frame with bad start/parity/stop discarded
//  timeout_err out  1   1-cycle pulse: frame aborted by timeout
//  overflow    out  1   1-cycle pulse: good byte dropped because FIFO full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM IDLE; tick counter 0; filtered scl/sda = 1; prefix flags cleared.
//  Reset mid-frame discards the partial frame. No stale entry survives reset.
//  Input path: 2-flop synchroniser per pin on clk. Filters update only on tick.
//  A filtered line toggles after FILTER_LEN consecutive opposite samples.
//  Falling edge = filtered scl 1->0 on a tick. Only falling edges shift bits (sda LSB first).
//  FSM (advances on ticks only):
//   IDLE  : on falling edge -> capture bit0, bit_cnt=1, timer=0, go RECV
//   RECV  : on falling edge -> shift, bit_cnt++, timer=0; when bit_cnt reaches 11 -> CHECK
//           no edge -> timer++; timer==TIMEOUT -> timeout_err pulse, clear prefix flags, IDLE
//   CHECK : on the next clk cycle (not tick-gated) -> go IDLE. Frame is good iff start==0, stop==1,
//           and ^{data,parity}==1 (odd). Bad -> parity_err pulse, clear prefix flags, no push.
//  Good byte, DECODE_PREFIX=1: E0 -> set ext_pend; F0 -> set brk_pend; neither pushed.
//   Any other byte -> push {ext_pend,brk_pend,byte}, then clear both flags.
//   E0 F0 xx yields ext=1, brk=1. Repeated prefixes leave flags set.
//  Good byte, DECODE_PREFIX=0: push {0,0,byte}.
//  Latency: entry is visible (valid=1) on the clk cycle after CHECK, i.e. 2 clk cycles after the
//   tick that sampled the stop-bit falling edge.
//  FIFO: show-ahead; pop when rd_en&&valid; new head is visible on the next cycle.
//   Push into a full FIFO -> entry dropped, overflow pulse, contents unchanged,
//   prefix flags still cleared.
//   Push and pop in the same cycle: both succeed, count unchanged. This holds even when full, so no overflow.
//   Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
//  Error pulses and overflow are mutually exclusive per frame. Each lasts exactly one clk cycle.
// TESTING (CLK_DIV=4, FILTER_LEN=2, TIMEOUT=40, FIFO_DEPTH=4 unless stated)
//  1 frame 0x1C, odd parity 0, clean -> valid=1, data_out=1C, ext=0, brk=0; rd_en 1 cycle -> valid=0
//  2 frames E0,F0,74 -> single entry data_out=74, ext=1, brk=1, fifo_count=1; parity_err never pulses
//  3 frame 0x1C with parity bit flipped -> parity_err 1 cycle, valid stays 0; next good 0x32 -> data_out=32, flags 0
//  4 send 6 bits then hold scl=1 for 50 ticks -> timeout_err once; then full frame 0x2B -> data_out=2B
//  5 five bytes 01..05 with no reads -> fifo_count=4, overflow once on 05, pops return 01,02,03,04
//  6 1-tick scl glitches inside a frame -> same result as clean; assert rst mid-frame -> all outputs 0, next frame ok

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: tick-sampled glitch filter, 11-bit framing with start/odd-parity/stop
// checks and stall timeout, E0/F0 prefix folding, and a show-ahead FIFO of decoded scan codes.
module ps2_rx_fifo #(
  parameter int CLK_DIV       = 250,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT       = 4000,
  parameter int FIFO_DEPTH    = 8,
  parameter int DECODE_PREFIX = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scl,
  input  logic                          sda,
  input  logic                          rd_en,
  output logic                          valid,
  output logic [7:0]                    data_out,
  output logic                          ext,
  output logic                          brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int TCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic DECODE = (DECODE_PREFIX != 0);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t           state;
  logic [TCW-1:0]   tick_cnt;
  logic             tick;
  logic [1:0]       scl_sync, sda_sync;
  logic             scl_f, sda_f, scl_nxt, sda_nxt;
  logic [FCW-1:0]   scl_cnt, sda_cnt, scl_cnt_nxt, sda_cnt_nxt;
  logic             fall;
  logic [10:0]      shreg;
  logic [3:0]       bit_cnt;
  logic [TOW-1:0]   timer;
  logic             ext_pend, brk_pend;
  logic             frame_good, is_ext, is_brk;
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, full, wr;
  logic [9:0]       head;

  assign tick = (tick_cnt == TCW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end

  // A filtered line flips only after FILTER_LEN consecutive ticks disagreeing with it.
  always_comb begin
    scl_nxt     = scl_f;
    sda_nxt     = sda_f;
    scl_cnt_nxt = scl_cnt;
    sda_cnt_nxt = sda_cnt;
    if (tick) begin
      if (scl_sync[1] == scl_f) begin
        scl_cnt_nxt = '0;
      end else if (scl_cnt == FCW'(FILTER_LEN - 1)) begin
        scl_nxt     = ~scl_f;
        scl_cnt_nxt = '0;
      end else begin
        scl_cnt_nxt = scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt_nxt = '0;
      end else if (sda_cnt == FCW'(FILTER_LEN - 1)) begin
        sda_nxt     = ~sda_f;
        sda_cnt_nxt = '0;
      end else begin
        sda_cnt_nxt = sda_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      scl_f   <= scl_nxt;
      sda_f   <= sda_nxt;
      scl_cnt <= scl_cnt_nxt;
      sda_cnt <= sda_cnt_nxt;
    end
  end

  assign fall       = tick && scl_f && !scl_nxt;
  assign frame_good = !shreg[0] && shreg[10] && (^shreg[9:1]);
  assign is_ext     = DECODE && (shreg[8:1] == 8'hE0);
  assign is_brk     = DECODE && (shreg[8:1] == 8'hF0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      timer       <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            shreg   <= {sda_nxt, shreg[10:1]};
            bit_cnt <= 4'd1;
            timer   <= '0;
            state   <= RECV;
          end
        end
        RECV: begin
          if (fall) begin
            shreg   <= {sda_nxt, shreg[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            timer   <= '0;
            if (bit_cnt == 4'd10) state <= CHECK;
          end else if (tick) begin
            if (timer == TOW'(TIMEOUT - 1)) begin
              timeout_err <= 1'b1;
              ext_pend    <= 1'b0;
              brk_pend    <= 1'b0;
              state       <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        CHECK: begin
          state <= IDLE;
          if (!frame_good) begin
            parity_err <= 1'b1;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
          end else if (is_ext) begin
            ext_pend <= 1'b1;
          end else if (is_brk) begin
            brk_pend <= 1'b1;
          end else begin
            // Flags are consumed by this byte even if the FIFO drops it.
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push = (state == CHECK) && frame_good && !is_ext && !is_brk;
  assign pop  = rd_en && valid;
  assign full = (count == CW'(FIFO_DEPTH));
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {ext_pend, brk_pend, shreg[8:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (!wr && pop) count <= count - 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign valid      = (count != '0);
  assign data_out   = valid ? head[7:0] : '0;
  assign ext        = valid ? head[9]   : 1'b0;
  assign brk        = valid ? head[8]   : 1'b0;
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboarded bench for ps2_rx_fifo: a keyboard driver feeds frames while a reference model
// queues expected entries; an independent reader process pops and compares FIFO heads.
module tb_ps2_rx_fifo;

  localparam int CLK_DIV    = 4;
  localparam int FILTER_LEN = 2;
  localparam int TIMEOUT    = 40;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF       = 32;

  logic       clk = 1'b0;
  logic       rst, scl, sda, rd_en;
  logic       valid, ext, brk, parity_err, timeout_err, overflow;
  logic [7:0] data_out;
  logic [2:0] fifo_count;

  ps2_rx_fifo #(
    .CLK_DIV(CLK_DIV),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT(TIMEOUT),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DECODE_PREFIX(1)
  ) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .rd_en(rd_en),
    .valid(valid), .data_out(data_out), .ext(ext), .brk(brk),
    .fifo_count(fifo_count), .parity_err(parity_err),
    .timeout_err(timeout_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];
  bit reader_en = 1'b0;
  bit ext_m = 1'b0, brk_m = 1'b0;
  int exp_perr = 0, exp_tmo = 0, exp_ovf = 0;
  int seen_perr = 0, seen_tmo = 0, seen_ovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reader/scoreboard: pops at random when the DUT presents an entry.
  initial begin
    logic [9:0] exp;
    rd_en = 1'b0;
    forever begin
      @(negedge clk);
      rd_en = 1'b0;
      if (rst === 1'b0 && reader_en && valid && $urandom_range(0, 1) == 1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_entry: got %0h expected none", {ext, brk, data_out});
        end else begin
          exp = exp_q.pop_front();
          if ({ext, brk, data_out} !== exp) begin
            n_fail++;
            $display("FAIL head_entry: got %0h expected %0h", {ext, brk, data_out}, exp);
          end
        end
        rd_en = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (parity_err)  seen_perr++;
      if (timeout_err) seen_tmo++;
      if (overflow)    seen_ovf++;
      if (32'(parity_err) + 32'(timeout_err) + 32'(overflow) > 1)
        check("pulse_exclusive", {parity_err, timeout_err, overflow}, 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input int err);
    logic st, par, sp;
    st  = (err == 2);
    par = (~^b) ^ (err == 1);
    sp  = (err != 3);
    return {sp, par, b, st};
  endfunction

  // Keyboard side: data set while scl high, sampled on falling edge; optional short glitches.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      sda = bits[i];
      if (glitch) begin
        wait_cycles(16); scl = 1'b0; wait_cycles(3); scl = 1'b1; wait_cycles(HALF - 19);
      end else wait_cycles(HALF);
      scl = 1'b0;
      if (glitch) begin
        wait_cycles(16); scl = 1'b1; wait_cycles(3); scl = 1'b0; wait_cycles(HALF - 19);
      end else wait_cycles(HALF);
      scl = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int err, input bit glitch);
    if (err != 0) begin
      exp_perr++;
      ext_m = 1'b0; brk_m = 1'b0;
    end else if (b == 8'hE0) begin
      ext_m = 1'b1;
    end else if (b == 8'hF0) begin
      brk_m = 1'b1;
    end else begin
      if (!reader_en && exp_q.size() >= FIFO_DEPTH) exp_ovf++;
      else exp_q.push_back({ext_m, brk_m, b});
      ext_m = 1'b0; brk_m = 1'b0;
    end
    send_bits(frame_bits(b, err), 11, glitch);
    wait_cycles(40 + $urandom_range(0, 40));
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    wait_cycles(5);
    check({name, "_valid_low"}, valid, 0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_parity_err_cnt"},  seen_perr, exp_perr);
    check({name, "_timeout_err_cnt"}, seen_tmo,  exp_tmo);
    check({name, "_overflow_cnt"},    seen_ovf,  exp_ovf);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_valid"}, valid, 0);
    check({name, "_data"},  {ext, brk, data_out}, 0);
    check({name, "_count"}, fifo_count, 0);
    check({name, "_pulses"}, {parity_err, timeout_err, overflow}, 0);
  endtask

  initial begin
    logic [7:0] b;
    int err;
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    wait_cycles(5);
    check_zero_outputs("reset");
    rst = 1'b0;
    wait_cycles(20);
    reader_en = 1'b1;

    send_byte(8'h1C, 0, 1'b0);
    drain("s1");
    check_counts("s1");

    reader_en = 1'b0;
    send_byte(8'hE0, 0, 1'b0);
    send_byte(8'hF0, 0, 1'b0);
    send_byte(8'h74, 0, 1'b0);
    wait_cycles(10);
    check("s2_count", fifo_count, 1);
    check("s2_head", {valid, ext, brk, data_out}, 11'h774);
    reader_en = 1'b1;
    drain("s2");
    check_counts("s2");

    send_byte(8'h1C, 1, 1'b0);
    check("s3_valid_after_bad", valid, 0);
    send_byte(8'h32, 0, 1'b0);
    drain("s3");
    check_counts("s3");

    send_byte(8'hE0, 0, 1'b0);
    send_bits(frame_bits(8'h2B, 0), 6, 1'b0);
    exp_tmo++;
    ext_m = 1'b0; brk_m = 1'b0;
    wait_cycles(50 * CLK_DIV);
    send_byte(8'h2B, 0, 1'b0);
    drain("s4");
    check_counts("s4");

    reader_en = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 0, 1'b0);
    wait_cycles(10);
    check("s5_count", fifo_count, 4);
    check_counts("s5_full");
    reader_en = 1'b1;
    drain("s5");

    send_byte(8'h5A, 0, 1'b1);
    send_byte(8'hF0, 0, 1'b1);
    send_byte(8'h6B, 0, 1'b1);
    drain("s6_glitch");
    check_counts("s6_glitch");

    reader_en = 1'b0;
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'hE0, 0, 1'b0);
    send_bits(frame_bits(8'h77, 0), 5, 1'b0);
    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    exp_q.delete();
    ext_m = 1'b0; brk_m = 1'b0;
    wait_cycles(3);
    check_zero_outputs("mid_reset");
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(20);
    check("post_reset_count", fifo_count, 0);
    reader_en = 1'b1;
    send_byte(8'h1C, 0, 1'b0);
    drain("s6_reset");
    check_counts("s6_reset");

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_byte(b, err, 1'($urandom_range(0, 1)));
    end
    drain("random");
    check_counts("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
